// File: rtl/ff_serial_pkg.sv
// Shared types and defaults for the serial data link transmitter.
package ff_serial_pkg;

   typedef enum logic {IDLE, SHIFT} ser_state_t;

   localparam int DEF_WIDTH = 4;

endpackage

// File: rtl/ff_bit_counter.sv
// Loadable down-counter with a zero flag. It holds at zero instead of wrapping.
module ff_bit_counter #(
   parameter int WIDTH = 4,
   localparam int CW = $clog2(WIDTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          dec,
   input  logic [CW-1:0] load_val,
   output logic [CW-1:0] count,
   output logic          zero
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (dec && (cnt_q != '0))
         cnt_d = cnt_q - 1'b1;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cnt_q <= '0;
      else      cnt_q <= cnt_d;
   end

   assign count = cnt_q;
   assign zero  = (cnt_q == '0);

endmodule

// File: rtl/ff_piso_serializer.sv
// Parallel-in/serial-out transmitter. It accepts a word on valid/ready and
// shifts it out one bit per clock.
module ff_piso_serializer
   import ff_serial_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter bit LSB_FIRST = 1'b0,
   localparam int CW = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             sdo,
   output logic             sdo_valid,
   output logic             done,
   output logic             busy
);

   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   ser_state_t       state_q, state_d;
   logic [WIDTH-1:0] shreg_q, shreg_d;
   logic             rdy_en_q, rdy_en_d;
   logic             cnt_load, cnt_dec, cnt_zero;
   logic [CW-1:0]    cnt;
   logic             accept;

   ff_bit_counter #(.WIDTH(WIDTH)) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .dec      (cnt_dec),
      .load_val (LAST),
      .count    (cnt),
      .zero     (cnt_zero)
   );

   // din_ready stays low through reset and rises on the first edge after release.
   assign din_ready = rdy_en_q && ((state_q == IDLE) || cnt_zero);
   assign accept    = din_valid && din_ready;

   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      rdy_en_d = 1'b1;
      cnt_load = 1'b0;
      cnt_dec  = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               shreg_d  = din;
               cnt_load = 1'b1;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            if (accept) begin
               shreg_d  = din;
               cnt_load = 1'b1;
            end else begin
               shreg_d = LSB_FIRST ? {1'b0, shreg_q[WIDTH-1:1]}
                                   : {shreg_q[WIDTH-2:0], 1'b0};
               cnt_dec = 1'b1;
               if (cnt_zero) state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         rdy_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         rdy_en_q <= rdy_en_d;
      end
   end

   assign busy      = (state_q == SHIFT);
   assign sdo_valid = busy;
   assign sdo       = busy && (LSB_FIRST ? shreg_q[0] : shreg_q[WIDTH-1]);
   assign done      = busy && cnt_zero;

endmodule

// File: tb/tb_ff_piso_serializer.sv
// Directed bench for ff_piso_serializer: an MSB-first instance with a loopback
// receiver, and an LSB-first instance.
module tb_ff_piso_serializer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] din0 = '0, din1 = '0;
   logic       din_valid0 = 1'b0, din_valid1 = 1'b0;
   logic       din_ready0, sdo0, sdo_valid0, done0, busy0;
   logic       din_ready1, sdo1, sdo_valid1, done1, busy1;
   logic [3:0] rx_q;
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   ff_piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .rst(rst), .din(din0), .din_valid(din_valid0),
      .din_ready(din_ready0), .sdo(sdo0), .sdo_valid(sdo_valid0),
      .done(done0), .busy(busy0)
   );

   ff_piso_serializer #(.WIDTH(4), .LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .rst(rst), .din(din1), .din_valid(din_valid1),
      .din_ready(din_ready1), .sdo(sdo1), .sdo_valid(sdo_valid1),
      .done(done1), .busy(busy1)
   );

   // Receiver: serial-in shift register, left shift, enabled by sdo_valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)            rx_q <= '0;
      else if (sdo_valid0) rx_q <= {rx_q[2:0], sdo0};
   end

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [3:0] w;
   logic [7:0] stream;

   initial begin
      // Reset release and first ready
      repeat (2) step();
      rst = 1'b1;
      chk("ready_before_edge", {7'd0, din_ready0}, 8'd0);
      step();
      chk("ready_after_release", {7'd0, din_ready0}, 8'd1);
      chk("idle_outs", {4'd0, sdo0, sdo_valid0, done0, busy0}, 8'd0);

      // Single word 1011, loopback into receiver
      din0 = 4'b1011; din_valid0 = 1'b1;
      step();
      din_valid0 = 1'b0; din0 = 4'b0000;
      w = 4'b1011;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("single_sdo%0d", i), {7'd0, sdo0}, {7'd0, w[3-i]});
         chk($sformatf("single_vld%0d", i), {6'd0, sdo_valid0, busy0}, 8'd3);
         chk($sformatf("single_done%0d", i), {7'd0, done0}, {7'd0, (i == 3)});
         step();
      end
      chk("single_idle", {6'd0, sdo_valid0, busy0}, 8'd0);
      chk("loopback_rx", {4'd0, rx_q}, 8'h0B);

      // Back-to-back A then 5, valid held high
      din0 = 4'hA; din_valid0 = 1'b1;
      step();
      din0 = 4'h5;
      stream = 8'b1010_0101;
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("b2b_sdo%0d", k), {7'd0, sdo0}, {7'd0, stream[7-k]});
         chk($sformatf("b2b_vld%0d", k), {7'd0, sdo_valid0}, 8'd1);
         chk($sformatf("b2b_done%0d", k), {7'd0, done0}, {7'd0, (k == 3 || k == 7)});
         if (k == 1) chk("b2b_notready_mid", {7'd0, din_ready0}, 8'd0);
         if (k == 7) din_valid0 = 1'b0;
         step();
      end
      chk("b2b_idle", {7'd0, sdo_valid0}, 8'd0);
      chk("b2b_rx", {4'd0, rx_q}, 8'h05);

      // Mid-word load attempt is ignored
      din0 = 4'hC; din_valid0 = 1'b1;
      step();
      din_valid0 = 1'b0;
      w = 4'hC;
      for (int k = 0; k < 4; k++) begin
         if (k == 1) begin din0 = 4'hF; din_valid0 = 1'b1; end
         if (k == 2) din_valid0 = 1'b0;
         chk($sformatf("ign_sdo%0d", k), {7'd0, sdo0}, {7'd0, w[3-k]});
         chk($sformatf("ign_done%0d", k), {7'd0, done0}, {7'd0, (k == 3)});
         step();
      end
      chk("ign_idle", {6'd0, sdo_valid0, busy0}, 8'd0);

      // LSB-first instance, 0001 -> 1,0,0,0
      din1 = 4'b0001; din_valid1 = 1'b1;
      step();
      din_valid1 = 1'b0;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("lsb_sdo%0d", k), {7'd0, sdo1}, {7'd0, (k == 0)});
         chk($sformatf("lsb_done%0d", k), {7'd0, done1}, {7'd0, (k == 3)});
         step();
      end
      chk("lsb_idle", {7'd0, sdo_valid1}, 8'd0);

      // Reset asserted mid-word
      din0 = 4'hF; din_valid0 = 1'b1;
      step();
      din_valid0 = 1'b0;
      step();
      chk("pre_reset_busy", {7'd0, busy0}, 8'd1);
      rst = 1'b0;
      #1;
      chk("mid_reset_outs", {3'd0, din_ready0, sdo0, sdo_valid0, done0, busy0}, 8'd0);
      step();
      rst = 1'b1;
      #1;
      chk("post_release_notready", {7'd0, din_ready0}, 8'd0);
      step();
      chk("post_release_ready", {7'd0, din_ready0}, 8'd1);
      chk("post_release_outs", {5'd0, sdo_valid0, done0, busy0}, 8'd0);
      step();
      chk("no_done_after_reset", {6'd0, done0, sdo_valid0}, 8'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
